// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the RV32I writeback stage.
//   - XLEN / REG_AW  : data and register-address widths
//   - wb_sel_e       : writeback source encoding (value 3 also selects ALU)
//   - F3_*           : load funct3 codes understood by the load extender
//   - mem_wb_t       : contents of the MEM/WB pipeline register
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // wb_sel is kept raw so the spare encoding 3 survives the register.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd_addr;
    logic              rd_wren;
    logic [1:0]        wb_sel;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   pc_plus4;
  } mem_wb_t;

endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: bus bundle between MEM stage / data memory, the writeback
// stage and the register file.
//   i_mem_*     : instruction fields from the MEM stage
//   i_ld_*      : load data word and its ready flag
//   o_stall_req : upstream hold request
//   o_rd_*      : register-file write port
//   o_fwd_*     : bypass copy of the write port
//   o_retire    : retire pulse, o_instret : retired-instruction count
// Modports: master = MEM/regfile side, slave = wb_stage.
interface wb_stage_if;
  import wb_pkg::*;

  logic              i_mem_valid;
  logic [REG_AW-1:0] i_mem_rd_addr;
  logic              i_mem_rd_wren;
  logic [1:0]        i_mem_wb_sel;
  logic [2:0]        i_mem_funct3;
  logic [XLEN-1:0]   i_mem_alu_result;
  logic [XLEN-1:0]   i_mem_pc_plus4;
  logic [XLEN-1:0]   i_ld_data;
  logic              i_ld_ready;
  logic              o_stall_req;
  logic [REG_AW-1:0] o_rd_addr;
  logic [XLEN-1:0]   o_rd_data;
  logic              o_rd_wren;
  logic              o_fwd_valid;
  logic [REG_AW-1:0] o_fwd_addr;
  logic [XLEN-1:0]   o_fwd_data;
  logic              o_retire;
  logic [63:0]       o_instret;

  modport master (
    output i_mem_valid, i_mem_rd_addr, i_mem_rd_wren, i_mem_wb_sel,
           i_mem_funct3, i_mem_alu_result, i_mem_pc_plus4, i_ld_data, i_ld_ready,
    input  o_stall_req, o_rd_addr, o_rd_data, o_rd_wren, o_fwd_valid,
           o_fwd_addr, o_fwd_data, o_retire, o_instret
  );

  modport slave (
    input  i_mem_valid, i_mem_rd_addr, i_mem_rd_wren, i_mem_wb_sel,
           i_mem_funct3, i_mem_alu_result, i_mem_pc_plus4, i_ld_data, i_ld_ready,
    output o_stall_req, o_rd_addr, o_rd_data, o_rd_wren, o_fwd_valid,
           o_fwd_addr, o_fwd_data, o_retire, o_instret
  );

endinterface

// File: rtl/load_ext.sv
// load_ext: combinational load-data extender.
//   i_raw    : aligned 32-bit word from data memory
//   i_funct3 : load type (LB/LH/LW/LBU/LHU; 011/110/111 behave as LW)
//   i_off    : byte offset (address bits [1:0]); halfwords use bit 1 only
//   o_value  : sign- or zero-extended result
module load_ext
  import wb_pkg::*;
(
  input  logic [XLEN-1:0] i_raw,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_off,
  output logic [XLEN-1:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and halfword out of the word.
  always_comb begin
    w_byte = i_raw[7:0];
    case (i_off)
      2'd0:    w_byte = i_raw[7:0];
      2'd1:    w_byte = i_raw[15:8];
      2'd2:    w_byte = i_raw[23:16];
      2'd3:    w_byte = i_raw[31:24];
      default: w_byte = i_raw[7:0];
    endcase
    if (i_off[1]) begin
      w_half = i_raw[31:16];
    end else begin
      w_half = i_raw[15:0];
    end
  end

  // Extend according to load type; unknown encodings pass the full word.
  always_comb begin
    o_value = i_raw;
    case (i_funct3)
      F3_LB:   o_value = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_value = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_value = {24'd0, w_byte};
      F3_LHU:  o_value = {16'd0, w_half};
      F3_LW:   o_value = i_raw;
      default: o_value = i_raw;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: RV32I writeback stage.
// Registers the MEM/WB boundary, selects ALU / load / PC+4 as writeback data,
// drives the register-file write port plus an identical bypass copy, and
// requests an upstream stall while a load waits for its data.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   bus            : wb_stage_if.slave (MEM inputs, regfile/bypass outputs)
// Optional build macro WB_INSTRET_EN: adds a 64-bit retired-instruction
// counter on o_instret; without it o_instret is tied to zero.
module wb_stage
  import wb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  wb_stage_if.slave  bus
);

  mem_wb_t         r_wb;
  logic            w_stall;
  logic            w_commit;
  logic            w_wren;
  logic [XLEN-1:0] w_ld_val;
  logic [XLEN-1:0] w_data;

  // A valid load without ready data holds WB and everything upstream.
  assign w_stall  = r_wb.valid & (r_wb.wb_sel == WB_LOAD) & ~bus.i_ld_ready;
  assign w_commit = r_wb.valid & ~w_stall;
  // x0 writes still retire but never touch the register file.
  assign w_wren   = w_commit & r_wb.rd_wren & (r_wb.rd_addr != 5'd0);

  // MEM/WB pipeline register: capture unless stalled.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wb <= '0;
    end else if (!w_stall) begin
      r_wb.valid      <= bus.i_mem_valid;
      r_wb.rd_addr    <= bus.i_mem_rd_addr;
      r_wb.rd_wren    <= bus.i_mem_rd_wren;
      r_wb.wb_sel     <= bus.i_mem_wb_sel;
      r_wb.funct3     <= bus.i_mem_funct3;
      r_wb.alu_result <= bus.i_mem_alu_result;
      r_wb.pc_plus4   <= bus.i_mem_pc_plus4;
    end else begin
      r_wb <= r_wb;
    end
  end

  load_ext u_load_ext (
    .i_raw    (bus.i_ld_data),
    .i_funct3 (r_wb.funct3),
    .i_off    (r_wb.alu_result[1:0]),
    .o_value  (w_ld_val)
  );

  // Writeback source select; the spare encoding 3 falls back to ALU.
  always_comb begin
    w_data = r_wb.alu_result;
    case (r_wb.wb_sel)
      WB_LOAD: w_data = w_ld_val;
      WB_PC4:  w_data = r_wb.pc_plus4;
      default: w_data = r_wb.alu_result;
    endcase
  end

  assign bus.o_stall_req = w_stall;
  assign bus.o_rd_addr   = r_wb.rd_addr;
  assign bus.o_rd_data   = w_data;
  assign bus.o_rd_wren   = w_wren;
  assign bus.o_fwd_valid = w_wren;
  assign bus.o_fwd_addr  = r_wb.rd_addr;
  assign bus.o_fwd_data  = w_data;
  assign bus.o_retire    = w_commit;

`ifdef WB_INSTRET_EN
  logic [63:0] r_instret;

  // Retired-instruction counter; wraps naturally at 2^64.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_instret <= 64'd0;
    end else if (w_commit) begin
      r_instret <= r_instret + 64'd1;
    end else begin
      r_instret <= r_instret;
    end
  end

  assign bus.o_instret = r_instret;
`else
  assign bus.o_instret = 64'd0;
`endif

endmodule
